// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for one 3-to-8 decoded resource shared by eight requesters.
// Holds the grant while the owner keeps requesting, bounded by MAX_HOLD cycles.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);

  state_t           state, state_d;
  logic [7:0]       gnt_d;
  logic [2:0]       idx_d;
  logic             vld_d;
  logic             pre_d;
  logic [2:0]       ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic       found;
  logic [2:0] win;
  logic [2:0] cand;
  logic       hit;
  logic       own_req;

  // first set request scanning from ptr upward, modulo 8
  always_comb begin
    win   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign hit     = (MAX_HOLD != 0) && (cnt == LAST);
  assign own_req = req[gnt_idx];

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    idx_d   = gnt_idx;
    vld_d   = gnt_vld;
    pre_d   = 1'b0;
    ptr_d   = ptr;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        gnt_d = 8'h00;
        vld_d = 1'b0;
        if (en && found) begin
          state_d = GRANT;
          gnt_d   = 8'b1 << win;
          idx_d   = win;
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt + 1'b1;
        if (!en || !own_req || hit) begin
          state_d = IDLE;
          gnt_d   = 8'h00;
          vld_d   = 1'b0;
          ptr_d   = gnt_idx + 3'd1;
          // a normal release or disable in the limit cycle is not a preemption
          pre_d   = en && own_req;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 8'h00;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
      preempt <= 1'b0;
      ptr     <= 3'd0;
      cnt     <= '0;
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      gnt_idx <= idx_d;
      gnt_vld <= vld_d;
      preempt <= pre_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: vector table, corner sequences,
// and random traffic against a tenure-level reference model.
module tb_decoder_rr_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  int total = 0;
  int bad   = 0;

  decoder_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       pre;
  } vec_t;

  vec_t tbl[24];

  // reference model: owner (-1 = none), rotation start, tenure length
  int m_owner;
  int m_ptr;
  int m_len;
  int m_idx;
  bit m_pre;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_len   = 0;
    m_idx   = 0;
    m_pre   = 1'b0;
  endtask

  task automatic m_step(input logic e, input logic [7:0] r);
    m_pre = 1'b0;
    if (m_owner < 0) begin
      if (e && r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int j;
          j = (m_ptr + k) % 8;
          if (m_owner < 0 && r[j]) begin
            m_owner = j;
            m_idx   = j;
            m_len   = 1;
          end
        end
      end
    end else if (!e || !r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (MH != 0 && m_len == MH) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_pre   = 1'b1;
    end else begin
      m_len++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic set_vec(int i, logic e, logic [7:0] r,
                         logic [7:0] g, logic p);
    tbl[i].en  = e;
    tbl[i].req = r;
    tbl[i].gnt = g;
    tbl[i].pre = p;
  endtask

  initial begin
    logic [7:0] exp_g;

    // preempt, wrap/skip, enable and simultaneous-release vectors
    set_vec(0,  1, 8'h09, 8'h01, 0);
    set_vec(1,  1, 8'h09, 8'h01, 0);
    set_vec(2,  1, 8'h09, 8'h01, 0);
    set_vec(3,  1, 8'h09, 8'h01, 0);
    set_vec(4,  1, 8'h09, 8'h00, 1);
    set_vec(5,  1, 8'h09, 8'h08, 0);
    set_vec(6,  1, 8'h09, 8'h08, 0);
    set_vec(7,  1, 8'h09, 8'h08, 0);
    set_vec(8,  1, 8'h09, 8'h08, 0);
    set_vec(9,  1, 8'h09, 8'h00, 1);
    set_vec(10, 1, 8'h05, 8'h01, 0);
    set_vec(11, 1, 8'h04, 8'h00, 0);
    set_vec(12, 1, 8'h05, 8'h04, 0);
    set_vec(13, 0, 8'h05, 8'h00, 0);
    set_vec(14, 0, 8'hFF, 8'h00, 0);
    set_vec(15, 0, 8'hFF, 8'h00, 0);
    set_vec(16, 1, 8'hFF, 8'h08, 0);
    set_vec(17, 1, 8'hFF, 8'h08, 0);
    set_vec(18, 1, 8'hFF, 8'h08, 0);
    set_vec(19, 1, 8'hFF, 8'h08, 0);
    set_vec(20, 1, 8'hF7, 8'h00, 0);
    set_vec(21, 1, 8'hFF, 8'h10, 0);
    set_vec(22, 1, 8'h00, 8'h00, 0);
    set_vec(23, 1, 8'h00, 8'h00, 0);

    do_reset();
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_vld", 32'(gnt_vld), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    chk("rst_pre", 32'(preempt), 32'h0);

    for (int i = 0; i < 24; i++) begin
      en  = tbl[i].en;
      req = tbl[i].req;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d_pre", i), 32'(preempt), 32'(tbl[i].pre));
      chk($sformatf("vec%0d_vld", i), 32'(gnt_vld),
          32'(tbl[i].gnt != 8'h00));
    end

    // reset mid-tenure clears outputs at once and rewinds the pointer
    en  = 1'b1;
    req = 8'h80;
    @(negedge clk);
    chk("pre_rst_gnt", 32'(gnt), 32'h80);
    req   = 8'hFF;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h00);
    chk("async_rst_vld", 32'(gnt_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'h01);

    // rotation: all request, each owner drops after two cycles
    do_reset();
    en  = 1'b1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h01 << (k % 8);
      @(negedge clk);
      chk($sformatf("rot%0d_a", k), 32'(gnt), 32'(exp_g));
      @(negedge clk);
      chk($sformatf("rot%0d_b", k), 32'(gnt), 32'(exp_g));
      req = ~exp_g;
      @(negedge clk);
      chk($sformatf("rot%0d_gap", k), 32'(gnt), 32'h00);
      req = 8'hFF;
    end

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 9) < 3)
        req = 8'($urandom());
      m_step(en, req);
      @(negedge clk);
      exp_g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      chk("rnd_gnt", 32'(gnt), 32'(exp_g));
      chk("rnd_vld", 32'(gnt_vld), 32'(m_owner >= 0));
      chk("rnd_idx", 32'(gnt_idx), 32'(m_idx));
      chk("rnd_pre", 32'(preempt), 32'(m_pre));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
